// File: rtl/nco_multi_if.sv
// Bus bundle between the sample-strobe/control side and the multi-channel NCO.
// The master drives frame controls; the slave returns samples and status.
interface nco_multi_if #(
  parameter int WIDTH       = 24,
  parameter int PHASE_WIDTH = 32,
  parameter int CHANNELS    = 2
);
  logic                            en;
  logic                            tick;
  logic [CHANNELS*PHASE_WIDTH-1:0] inc;
  logic [CHANNELS*2-1:0]           mode;
  logic [CHANNELS-1:0]             sync;
  logic [CHANNELS*WIDTH-1:0]       wav;
  logic                            valid;
  logic                            ovf;

  modport master (output en, tick, inc, mode, sync, input wav, valid, ovf);
  modport slave  (input en, tick, inc, mode, sync, output wav, valid, ovf);
endinterface

// File: rtl/nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators sharing one synchronous
// cosine LUT, time-multiplexed once per sample tick, with saw/triangle/square modes.
//
// state    | meaning
// S_IDLE   | waiting for tick & en
// S_RUN    | channel counter ch steps 0..CHANNELS-1, one LUT access per cycle
// S_FLUSH0 | pipeline drain, first cycle
// S_FLUSH1 | pipeline drain, second cycle
module nco_multi #(
  parameter int WIDTH       = 24,
  parameter int DEPTH       = 1024,
  parameter int PHASE_WIDTH = 32,
  parameter int CHANNELS    = 2
) (
  input logic         clk,
  input logic         rst_n,
  nco_multi_if.slave  bus
);
  localparam int PHI_WIDTH = $clog2(DEPTH);
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] POS_FS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_FS  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  // ROM contents are fixed at elaboration: full-scale cosine, rounded to nearest
  function automatic logic [WIDTH-1:0] cos_entry(input int idx);
    real r;
    r = (2.0 ** (WIDTH - 1) - 1.0) * $cos(2.0 * 3.141592653589793 * idx / DEPTH);
    if (r >= 0.0) cos_entry = WIDTH'($rtoi(r + 0.5));
    else          cos_entry = WIDTH'(-$rtoi(0.5 - r));
  endfunction

  logic [WIDTH-1:0] lut_rom [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [WIDTH-1:0] ENTRY = cos_entry(i);
    assign lut_rom[i] = ENTRY;
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH0, S_FLUSH1} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic              start, run, busy_tick;

  logic [PHASE_WIDTH-1:0] phase    [CHANNELS];
  logic [PHASE_WIDTH-1:0] inc_snap [CHANNELS];
  logic [1:0]             mode_snap[CHANNELS];
  logic [CHANNELS-1:0]    sync_snap;

  logic [PHASE_WIDTH-1:0] p;
  logic [PHI_WIDTH-1:0]   addr;
  logic [WIDTH-1:0]       saw, tri_f, tri_w, gen;

  logic                   s1_vld;
  logic [CH_W-1:0]        s1_ch;
  logic [1:0]             s1_mode;
  logic [WIDTH-1:0]       s1_gen, lut_q;

  logic [WIDTH-1:0]       wav_r [CHANNELS];
  logic                   valid_r, ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      if (start)    ch <= '0;
      else if (run) ch <= ch + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_RUN;
      S_RUN:    if (ch == CH_LAST) state_nxt = S_FLUSH0;
      S_FLUSH0: state_nxt = S_FLUSH1;
      S_FLUSH1: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // A tick seen in any non-idle state, including the last flush cycle, is an overrun
  always_comb begin
    start     = (state == S_IDLE) && bus.tick && bus.en;
    run       = (state == S_RUN);
    busy_tick = (state != S_IDLE) && bus.tick;
  end

  always_comb begin
    p     = sync_snap[ch] ? '0 : phase[ch];
    addr  = p[PHASE_WIDTH-1 -: PHI_WIDTH];
    saw   = {~p[PHASE_WIDTH-1], p[PHASE_WIDTH-2 -: WIDTH-1]};
    tri_f = p[PHASE_WIDTH-1] ? ~p[PHASE_WIDTH-2 -: WIDTH] : p[PHASE_WIDTH-2 -: WIDTH];
    tri_w = {~tri_f[WIDTH-1], tri_f[WIDTH-2:0]};
    case (mode_snap[ch])
      2'b01:   gen = saw;
      2'b10:   gen = tri_w;
      2'b11:   gen = p[PHASE_WIDTH-1] ? NEG_FS : POS_FS;
      default: gen = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        phase[k]     <= '0;
        inc_snap[k]  <= '0;
        mode_snap[k] <= '0;
      end
      sync_snap <= '0;
    end else begin
      if (start) begin
        for (int k = 0; k < CHANNELS; k++) begin
          inc_snap[k]  <= bus.inc[k*PHASE_WIDTH +: PHASE_WIDTH];
          mode_snap[k] <= bus.mode[2*k +: 2];
        end
        sync_snap <= bus.sync;
      end
      if (run) phase[ch] <= p + inc_snap[ch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_ch   <= '0;
      s1_mode <= '0;
      s1_gen  <= '0;
      lut_q   <= '0;
    end else begin
      s1_vld  <= run;
      s1_ch   <= ch;
      s1_mode <= mode_snap[ch];
      s1_gen  <= gen;
      lut_q   <= lut_rom[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) wav_r[k] <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (s1_vld) wav_r[s1_ch] <= (s1_mode == 2'b00) ? lut_q : s1_gen;
      valid_r <= s1_vld && (s1_ch == CH_LAST);
      if (busy_tick) ovf_r <= 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_wav
    assign bus.wav[k*WIDTH +: WIDTH] = wav_r[k];
  end
  assign bus.valid = valid_r;
  assign bus.ovf   = ovf_r;

endmodule
